pdm_pcm_recorder: RTL and testbench
===================================

# pdm_pcm_recorder

Downstream consumer of the PDM deserializer. Takes each 16-bit PDM word plus its `done` strobe and reduces it to a one-count (popcount). It sums `DECIM` consecutive counts into one unsigned PCM sample and buffers the samples in an internal FIFO. A valid/ready port drains the FIFO to memory or playback logic, under a start/stop recording state machine.

## Interface
- `DECIM`, 4: words summed per PCM sample; legal range 1..16.
- `DEPTH`, 16: FIFO depth in samples; power of two, at least 2.
- `MAX_SAMPLES`, 1024: samples pushed before recording ends automatically; 0 means unlimited.

- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a recording.
- `stop`  in  1  one-cycle pulse that ends a recording.
- `word_valid`  in  1  deserializer `done` strobe; qualifies `word_in`.
- `word_in`  in  16  PDM word from the deserializer.
- `out_valid`  out  1  FIFO is non-empty.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_data`  out  16  head-of-FIFO PCM sample.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `busy`  out  1  FSM is not in IDLE.
- `rec_done`  out  1  one-cycle pulse on return to IDLE.
- `overflow`  out  1  sticky flag: a sample was dropped because the FIFO was full.

## Operation
- FSM states:
  - IDLE: words ignored. `start` clears `overflow`, the accumulator, the word counter and the sample counter, then moves to RECORD.
  - RECORD: each `word_valid` adds popcount(`word_in`), 0..16, to the accumulator.
    - On the `DECIM`-th word the sum is pushed and the accumulator clears.
    - The sum includes the current word, so the sample range is 0..16·`DECIM`, zero-extended to 16 bits.
    - Moves to FLUSH on `stop`, or in the same cycle the `MAX_SAMPLES`-th sample push is attempted, when `MAX_SAMPLES` is not 0.
  - FLUSH: words ignored. Moves to IDLE once `level`=0, pulsing `rec_done` that cycle.
- `stop` during RECORD discards the partial accumulation.
- `stop` arriving together with a completing word: the sample is pushed first, then the FSM moves to FLUSH.
- `start` outside IDLE, and `stop` outside RECORD, are ignored.
- `start` and `stop` together in IDLE: `start` wins.
- Full-FIFO push:
  - Without a pop in the same cycle, the sample is dropped, `overflow` is set, and the sample still counts toward `MAX_SAMPLES`.
  - With `out_valid`&`out_ready` in the same cycle, the push is accepted and `level` is unchanged.
- Push and pop in the same cycle on a non-full FIFO: `level` is unchanged.
- Pointers wrap modulo `DEPTH`.
- The FIFO is never flushed by `start`. Samples left over from a previous recording drain normally.

## Timing
- Reset values: state IDLE; FIFO empty; `out_valid`=0, `out_data`=0, `level`=0, `busy`=0, `rec_done`=0, `overflow`=0; all counters 0.
- `reset_n` low mid-recording aborts immediately. No `rec_done` pulse is produced and FIFO contents are lost.
- Latency: a completing `word_valid` in cycle t gives `out_valid`=1 and the sample on `out_data` in cycle t+1 (FIFO previously empty).
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- A pop in cycle t presents the next sample in cycle t+1.
- `busy` rises in the cycle after `start` and falls in the cycle after `rec_done`.
- `word_valid` may be asserted every cycle. No back-pressure is applied to the deserializer.

## Configuration
- `PDM_REC_DROP_CNT_EN` defined:
  - Adds output `drop_count` (out, 8 bits, reset 0).
  - Increments on each dropped sample and saturates at 255.
  - Cleared by `start` in IDLE.
- Undefined: the port and its counter do not exist; only the sticky `overflow` flag reports drops.

## Structure
- Package `pdm_rec_pkg`:
  - State enum `rec_state_t` (IDLE, RECORD, FLUSH).
  - Function `popcount16`.
  - Constants `PCM_W`=16 and `PDM_W`=16.
- Sub-module `pcm_sample_fifo`:
  - Parameterised by `DEPTH` and width.
  - Ports: push, pop, full, empty, level.
  - Supports simultaneous push and pop when full.
- The top level holds the FSM, the accumulator, the word counter and the sample counter.

## Test plan
- `DECIM`=4, `start`, four words 16'hFFFF → one sample 16'h0040, `out_valid` one cycle after the 4th `word_valid`.
- Words 16'h0F0F, 16'h0001, 16'h0000, 16'h8000 → sample 16'h000A.
- `DEPTH`=16, `out_ready`=0, 17 samples → `level`=16 and `overflow`=1; the 17th sample is dropped; with macro defined, `drop_count`=1. The next `start` clears both.
- `MAX_SAMPLES`=3, `out_ready`=1 → after the 3rd push the FSM enters FLUSH; `rec_done` pulses once the FIFO is empty, then `busy`=0.
- `stop` after 2 of 4 words → no sample pushed, `rec_done` pulses with `level`=0. Full FIFO with push and pop in the same cycle → `level` stays 16 and `overflow` stays 0.
- `reset_n` low mid-RECORD with `level`=5 → next cycle `level`=0, `out_valid`=0, `busy`=0, no `rec_done` pulse.

Source files
------------

// File: rtl/pdm_rec_pkg.sv
// pdm_rec_pkg
//   Shared types and helpers for the PDM-to-PCM recorder.
//   - rec_state_t : recorder FSM states
//   - popcount16  : number of ones in a 16-bit PDM word (0..16)
//   - PCM_W/PDM_W : sample and PDM word widths
package pdm_rec_pkg;

  localparam int PCM_W = 16;
  localparam int PDM_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    FLUSH  = 2'd2
  } rec_state_t;

  function automatic logic [4:0] popcount16(input logic [PDM_W-1:0] w);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < PDM_W; i++) begin
      c = c + 5'(w[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/pcm_sample_fifo.sv
// pcm_sample_fifo
//   Synchronous FIFO for PCM samples. A push into a full FIFO is accepted
//   only when a pop happens in the same cycle; otherwise it is discarded
//   (the parent decides how to report that).
// Ports:
//   clock, reset_n : clock, async active-low reset
//   push, wdata    : write request and data
//   pop            : read request (ignored when empty)
//   rdata          : head-of-FIFO data, 0 when empty
//   full, empty    : occupancy flags
//   level          : current occupancy, 0..DEPTH
module pcm_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_do_pop;
  logic w_do_push;

  assign empty     = (r_level == '0);
  assign full      = (r_level == LVL_W'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  // A full FIFO frees the head slot in the same cycle a pop happens.
  assign w_do_push = push & (~full | w_do_pop);
  assign level     = r_level;
  // Storage is not reset, so gate the head with empty to keep out_data at 0.
  assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/pdm_pcm_recorder.sv
// pdm_pcm_recorder
//   Reduces each PDM word to its popcount, sums DECIM counts into one PCM
//   sample, buffers samples in a FIFO and drains them over valid/ready,
//   under a start/stop recording FSM.
//
//   state  | meaning
//   IDLE   | words ignored; start clears counters/flags and begins recording
//   RECORD | accumulate popcounts; push a sample every DECIM words
//   FLUSH  | words ignored; wait for FIFO empty, then pulse rec_done
//
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   start, stop             : one-cycle recording control pulses
//   word_valid, word_in     : PDM word from the deserializer
//   out_valid/out_ready/out_data : sample output handshake
//   level                   : FIFO occupancy
//   busy, rec_done          : FSM not idle / return-to-idle pulse
//   overflow                : sticky sample-dropped flag
//   drop_count              : saturating drop counter (PDM_REC_DROP_CNT_EN only)
// Build option: define PDM_REC_DROP_CNT_EN to add drop_count.
module pdm_pcm_recorder
  import pdm_rec_pkg::*;
#(
  parameter int          DECIM       = 4,
  parameter int          DEPTH       = 16,
  parameter int unsigned MAX_SAMPLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   word_valid,
  input  logic [PDM_W-1:0]       word_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PCM_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   rec_done,
  output logic                   overflow
`ifdef PDM_REC_DROP_CNT_EN
  ,
  output logic [7:0]             drop_count
`endif
);

  rec_state_t       r_state;
  rec_state_t       w_next_state;
  logic [PCM_W-1:0] r_acc;
  logic [4:0]       r_word_cnt;
  logic [31:0]      r_sample_cnt;
  logic             r_overflow;

  logic             w_rec;
  logic             w_last;
  logic [PCM_W-1:0] w_sum;
  logic             w_push;
  logic             w_pop_fire;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic             w_max_hit;

  assign w_rec      = (r_state == RECORD);
  assign w_last     = (r_word_cnt == 5'(DECIM - 1));
  // Sum includes the current word so a completing word is pushed directly.
  assign w_sum      = r_acc + PCM_W'(popcount16(word_in));
  assign w_push     = w_rec & word_valid & w_last;
  assign w_pop_fire = out_valid & out_ready;
  assign w_drop     = w_push & w_full & ~w_pop_fire;
  // Dropped samples still count, so this fires on the attempted push.
  assign w_max_hit  = (MAX_SAMPLES != 0) && (r_sample_cnt == 32'(MAX_SAMPLES - 1));

  assign out_valid  = ~w_empty;
  assign busy       = (r_state != IDLE);
  assign overflow   = r_overflow;

  pcm_sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PCM_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (w_push),
    .wdata   (w_sum),
    .pop     (out_ready),
    .rdata   (out_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (level)
  );

  always_comb begin
    w_next_state = r_state;
    rec_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = RECORD;
      end
      RECORD: begin
        if (stop || (w_push && w_max_hit)) w_next_state = FLUSH;
      end
      FLUSH: begin
        if (level == '0) begin
          w_next_state = IDLE;
          rec_done     = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_word_cnt   <= '0;
      r_sample_cnt <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE) begin
        if (start) begin
          r_acc        <= '0;
          r_word_cnt   <= '0;
          r_sample_cnt <= '0;
          r_overflow   <= 1'b0;
        end
      end else if (w_rec) begin
        if (w_push) begin
          r_acc        <= '0;
          r_word_cnt   <= '0;
          r_sample_cnt <= r_sample_cnt + 32'd1;
        end else if (word_valid) begin
          r_acc      <= w_sum;
          r_word_cnt <= r_word_cnt + 5'd1;
        end
        // Leaving RECORD discards any partial accumulation.
        if (w_next_state == FLUSH) begin
          r_acc      <= '0;
          r_word_cnt <= '0;
        end
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef PDM_REC_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  assign drop_count = r_drop_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (r_state == IDLE && start) begin
      r_drop_cnt <= '0;
    end else if (w_drop && r_drop_cnt != 8'hFF) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pdm_pcm_recorder.sv
// Self-checking bench for pdm_pcm_recorder. Instance u_dut uses the default
// parameters; u_dut_b shares all inputs but has MAX_SAMPLES=3 and is only
// checked in the auto-stop sequence.
module tb_pdm_pcm_recorder;

  localparam int DECIM = 4;
  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        word_valid = 1'b0;
  logic [15:0] word_in = '0;
  logic        out_ready = 1'b0;

  logic        out_valid, busy, rec_done, overflow;
  logic [15:0] out_data;
  logic [4:0]  level;
  logic        out_valid_b, busy_b, rec_done_b, overflow_b;
  logic [15:0] out_data_b;
  logic [4:0]  level_b;
`ifdef PDM_REC_DROP_CNT_EN
  logic [7:0]  drop_count, drop_count_b;
`endif

  pdm_pcm_recorder #(.DECIM(DECIM), .DEPTH(DEPTH), .MAX_SAMPLES(1024)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .word_valid(word_valid), .word_in(word_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .busy(busy), .rec_done(rec_done), .overflow(overflow)
`ifdef PDM_REC_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  pdm_pcm_recorder #(.DECIM(DECIM), .DEPTH(DEPTH), .MAX_SAMPLES(3)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .word_valid(word_valid), .word_in(word_in),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .level(level_b), .busy(busy_b), .rec_done(rec_done_b), .overflow(overflow_b)
`ifdef PDM_REC_DROP_CNT_EN
    , .drop_count(drop_count_b)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic [3:0][15:0] w;
    logic [15:0]      exp;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected sample;
  // out_data must hold while valid is stalled.
  logic        hold_v = 1'b0;
  logic [15:0] hold_d = '0;
  always @(negedge clock) begin
    if (!reset_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) check("hold_stable", out_data, hold_d);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_pop: got sample %0h expected none", out_data);
        end else begin
          check("sb_sample", out_data, sb.pop_front());
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ones(input int n);
    logic [16:0] t;
    t = (17'd1 << n) - 17'd1;
    return t[15:0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    word_valid = 1'b1;
    word_in    = w;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_done(input bit use_b, input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (use_b ? rec_done_b : rec_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit seen;
    logic [15:0] w;

    vecs[0].w = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; vecs[0].exp = 16'h0040;
    vecs[1].w = {16'h8000, 16'h0000, 16'h0001, 16'h0F0F}; vecs[1].exp = 16'h000A;
    vecs[2].w = {16'h0000, 16'h0000, 16'h0000, 16'h0000}; vecs[2].exp = 16'h0000;
    vecs[3].w = {16'h0003, 16'h00FF, 16'h5555, 16'hAAAA}; vecs[3].exp = 16'h001A;
    vecs[4].w = {16'h7FFF, 16'h8001, 16'hFFFE, 16'h1234}; vecs[4].exp = 16'h0025;

    // Reset values
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_rec_done", rec_done, 0);
    check("rst_overflow", overflow, 0);
`ifdef PDM_REC_DROP_CNT_EN
    check("rst_drop_count", drop_count, 0);
`endif
    reset_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Table vectors, drained continuously
    out_ready = 1'b1;
    pulse_start();
    check("start_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < DECIM; j++) begin
        if (j == DECIM - 1) sb.push_back(vecs[i].exp);
        send_word(vecs[i].w[j]);
      end
      check("vec_latency_valid", out_valid, 1);
      check("vec_data", out_data, vecs[i].exp);
    end

    // Stop after 2 of 4 words: partial sum discarded
    send_word(16'hFFFF);
    send_word(16'hFFFF);
    pulse_stop();
    wait_done(1'b0, 20, seen);
    check("stop_partial_rec_done", seen, 1);
    check("stop_partial_level", level, 0);
    tick();
    check("stop_partial_busy", busy, 0);
    check("stop_partial_valid", out_valid, 0);
    check("stop_partial_sb_empty", sb.size(), 0);

    // Fill FIFO, push+pop while full, then drop one sample
    out_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      w = ones((k + 1) % 17);
      sb.push_back(16'(4 * ((k + 1) % 17)));
      for (int j = 0; j < DECIM; j++) send_word(w);
    end
    check("full_level", level, 16);
    check("full_overflow", overflow, 0);
    w = ones(17 % 17);
    for (int j = 0; j < DECIM - 1; j++) send_word(w);
    sb.push_back(16'(4 * (17 % 17)));
    out_ready = 1'b1;
    send_word(w);
    out_ready = 1'b0;
    check("full_pushpop_level", level, 16);
    check("full_pushpop_overflow", overflow, 0);
    w = ones(1);
    for (int j = 0; j < DECIM; j++) send_word(w);
    check("drop_level", level, 16);
    check("drop_overflow", overflow, 1);
`ifdef PDM_REC_DROP_CNT_EN
    check("drop_count", drop_count, 1);
`endif
    pulse_stop();
    check("flush_busy", busy, 1);
    check("flush_no_done", rec_done, 0);
    out_ready = 1'b1;
    wait_done(1'b0, 40, seen);
    check("flush_rec_done", seen, 1);
    check("flush_sb_empty", sb.size(), 0);
    tick();
    check("flush_busy_low", busy, 0);

    // start+stop together in IDLE: start wins and clears the sticky flag
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", busy, 1);
    check("restart_overflow", overflow, 0);
`ifdef PDM_REC_DROP_CNT_EN
    check("restart_drop_count", drop_count, 0);
`endif
    pulse_stop();
    wait_done(1'b0, 10, seen);
    check("restart_rec_done", seen, 1);
    tick();

    // Reset mid-RECORD with level=5
    out_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < DECIM; j++) send_word(ones(3));
    check("prereset_level", level, 5);
    check("prereset_busy", busy, 1);
    reset_n = 1'b0;
    @(negedge clock);
    check("midrst_level", level, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rec_done", rec_done, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("postrst_rec_done", rec_done, 0);
    check("postrst_level", level, 0);

    // MAX_SAMPLES=3 auto-stop on u_dut_b
    out_ready = 1'b1;
    pulse_start();
    check("max_b_busy", busy_b, 1);
    for (int k = 0; k < 3; k++) begin
      w = ones(k + 2);
      for (int j = 0; j < DECIM; j++) begin
        if (j == DECIM - 1) sb.push_back(16'(4 * (k + 2)));
        send_word(w);
      end
    end
    check("max_b_flush_busy", busy_b, 1);
    check("max_b_level", level_b, 1);
    check("max_b_data", out_data_b, 16'h0010);
    check("max_b_no_done_yet", rec_done_b, 0);
    wait_done(1'b1, 10, seen);
    check("max_b_rec_done", seen, 1);
    check("max_b_level_zero", level_b, 0);
    tick();
    check("max_b_busy_low", busy_b, 0);
    w = ones(5);
    for (int j = 0; j < DECIM; j++) begin
      if (j == DECIM - 1) sb.push_back(16'h0014);
      send_word(w);
    end
    check("max_b_idle_valid", out_valid_b, 0);
    check("max_b_idle_level", level_b, 0);
    check("max_a_still_busy", busy, 1);
    pulse_stop();
    wait_done(1'b0, 20, seen);
    check("final_rec_done", seen, 1);
    repeat (3) tick();
    check("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
